dac_spi_ctrl: RTL

//  Parametrised SPI master for the LTC2624-family quad DAC (12/14/16-bit).

---
 rtl/dac_spi_ctrl.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/dac_spi_ctrl.sv
// SPI master for the LTC2624-family quad DAC: builds the 32-bit command frame,
// shifts it out MSB first, drives CS/CLR, and echo-checks the DAC_OUT readback.
module dac_spi_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int DATA_W     = 12,
    parameter int NUM_CH     = 4,
    parameter int CS_GAP     = 2,
    parameter int CLR_CYCLES = 2,
    parameter bit EN_ECHO    = 1'b1
) (
    input  logic              CLK50MHZ,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cmd,
    input  logic [3:0]        req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              done,
    output logic              addr_err,
    output logic              echo_err,
    output logic [31:0]       rdata,
    output logic              SPI_MOSI,
    output logic              SPI_SCK,
    output logic              DAC_CS,
    output logic              DAC_CLR,
    input  logic              DAC_OUT,
    output logic [2:0]        dbg_state
);
    localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [4:0]      NUM_CH_L = 5'(NUM_CH);
    localparam logic [15:0]     GAP_LAST = 16'(CS_GAP - 1);
    localparam logic [15:0]     CLR_LAST = 16'(CLR_CYCLES - 1);
    localparam int              JUST     = 16 - DATA_W;

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_GAP, ST_CLR} state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [5:0]        tog_q, tog_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [31:0]       tx_q, tx_d, rx_q, rx_d, word_q, word_d, prev_q, prev_d;
    logic              sck_q, sck_d, cs_q, cs_d, clr_n_q, clr_n_d, mosi_q, mosi_d;
    logic              done_q, done_d, addr_err_q, addr_err_d, echo_err_q, echo_err_d;
    logic              hist_q, hist_d, clr_pend_q, clr_pend_d;
    logic [15:0]       data_lj;
    logic [31:0]       frame_w;
    logic              bad_addr, accept, tick;

    // Handshake: a request transfers on any clk edge where req_valid && req_ready;
    // ready is only offered in IDLE with no clear waiting, so clears win ties.
    assign req_ready = (state_q == ST_IDLE) && !clr_req && !clr_pend_q && !RST;
    assign accept    = req_valid && req_ready;
    assign bad_addr  = ({1'b0, req_addr} >= NUM_CH_L) && (req_addr != 4'hF);
    assign data_lj   = 16'(req_data) << JUST;
    assign frame_w   = {8'h00, req_cmd, req_addr, data_lj};
    assign tick      = (div_q == DIV_LAST);

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        tog_d      = tog_q;
        cnt_d      = cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        word_d     = word_q;
        prev_d     = prev_q;
        sck_d      = sck_q;
        cs_d       = cs_q;
        clr_n_d    = clr_n_q;
        mosi_d     = mosi_q;
        done_d     = 1'b0;
        addr_err_d = 1'b0;
        echo_err_d = echo_err_q;
        hist_d     = hist_q;
        clr_pend_d = clr_pend_q;
        case (state_q)
            ST_IDLE: begin
                if (clr_req || clr_pend_q) begin
                    state_d    = ST_CLR;
                    clr_n_d    = 1'b0;
                    cnt_d      = '0;
                    clr_pend_d = 1'b0;
                    hist_d     = 1'b0;
                end else if (accept) begin
                    if (bad_addr) begin
                        addr_err_d = 1'b1;
                    end else begin
                        state_d    = ST_LOAD;
                        cs_d       = 1'b0;
                        tx_d       = frame_w;
                        word_d     = frame_w;
                        mosi_d     = frame_w[31];
                        div_d      = '0;
                        tog_d      = '0;
                        echo_err_d = 1'b0;
                    end
                end
            end
            ST_LOAD, ST_SHIFT: begin
                clr_pend_d = clr_pend_q || clr_req;
                state_d    = ST_SHIFT;
                if (tick) begin
                    div_d = '0;
                    sck_d = !sck_q;
                    tog_d = tog_q + 6'd1;
                    if (!sck_q) begin
                        rx_d = {rx_q[30:0], DAC_OUT};
                    end else begin
                        // Falling edge: advance MOSI; the 64th toggle closes the frame.
                        tx_d   = {tx_q[30:0], 1'b0};
                        mosi_d = tx_q[30];
                        if (tog_q == 6'd63) begin
                            state_d    = ST_GAP;
                            cs_d       = 1'b1;
                            cnt_d      = '0;
                            done_d     = 1'b1;
                            hist_d     = 1'b1;
                            prev_d     = word_q;
                            echo_err_d = EN_ECHO && hist_q && (rx_q != prev_q);
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_GAP: begin
                clr_pend_d = clr_pend_q || clr_req;
                if (cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + 16'd1;
            end
            ST_CLR: begin
                if (cnt_q == CLR_LAST) begin
                    clr_n_d = 1'b1;
                    state_d = ST_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK50MHZ) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            tog_q      <= '0;
            cnt_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            word_q     <= '0;
            prev_q     <= '0;
            sck_q      <= 1'b0;
            cs_q       <= 1'b1;
            clr_n_q    <= 1'b1;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
            echo_err_q <= 1'b0;
            hist_q     <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            tog_q      <= tog_d;
            cnt_q      <= cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            word_q     <= word_d;
            prev_q     <= prev_d;
            sck_q      <= sck_d;
            cs_q       <= cs_d;
            clr_n_q    <= clr_n_d;
            mosi_q     <= mosi_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
            echo_err_q <= echo_err_d;
            hist_q     <= hist_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign addr_err  = addr_err_q;
    assign echo_err  = echo_err_q;
    assign rdata     = rx_q;
    assign SPI_MOSI  = mosi_q;
    assign SPI_SCK   = sck_q;
    assign DAC_CS    = cs_q;
    assign DAC_CLR   = clr_n_q;
    assign dbg_state = state_q;
endmodule
